// File: rtl/serial_add_seq_pkg.sv
// Shared ALU definitions: sequencer state encoding and sizing helpers.
package serial_add_seq_pkg;

    localparam int unsigned STATE_W = 2;

    // Sequencer states; encoding 2'd3 is unused and recovers to IDLE.
    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a bit-index counter that addresses 0..width-1.
    function automatic int unsigned idx_width(input int unsigned width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder_gp.sv
// One-bit full adder that also exposes its generate and propagate terms.
module full_adder_gp (
    output logic s,
    output logic c,
    output logic g,
    output logic p,
    input  logic a,
    input  logic b,
    input  logic c0
);

    assign g = a & b;
    assign p = a ^ b;
    assign s = p ^ c0;
    assign c = g | (p & c0);

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial adder: one full-adder cell walks the operands LSB-first,
// building the sum, the final carry and group generate/propagate.
module serial_add_seq
    import serial_add_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             g_all,
    output logic             p_all
);

    localparam int unsigned IDX_W = idx_width(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;

    logic cell_s;
    logic cell_c;
    logic cell_g;
    logic cell_p;

    // Single shared adder cell; cout doubles as the running carry register.
    full_adder_gp u_cell (
        .s  (cell_s),
        .c  (cell_c),
        .g  (cell_g),
        .p  (cell_p),
        .a  (a_q[idx]),
        .b  (b_q[idx]),
        .c0 (cout)
    );

    // Sequencer, datapath registers and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            g_all <= 1'b0;
            p_all <= 1'b0;
            ready <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
                        cout  <= cin;
                        idx   <= '0;
                        sum   <= '0;
                        g_all <= 1'b0;
                        p_all <= 1'b1;
                        state <= RUN;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    sum[idx] <= cell_s;
                    cout     <= cell_c;
                    g_all    <= cell_g | (cell_p & g_all);
                    p_all    <= cell_p & p_all;
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: doc/serial_add_seq.md
SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, giving operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start, input, 1 bit: request to begin an addition, sampled only in IDLE.
REQ-005 SHALL have ports a and b, input, WIDTH bits each: operands, captured on the accepting edge.
REQ-006 SHALL have port cin, input, 1 bit: carry-in, captured with a and b.
REQ-007 SHALL have port ready, output, 1 bit: high exactly while in IDLE.
REQ-008 SHALL have port busy, output, 1 bit: high exactly while in RUN.
REQ-009 SHALL have port done, output, 1 bit: high exactly while in DONE, for one cycle per operation.
REQ-010 SHALL have port sum, output, WIDTH bits: the result.
REQ-011 SHALL have port cout, output, 1 bit: the final carry.
REQ-012 SHALL have ports g_all and p_all, output, 1 bit each: group generate and group propagate over all WIDTH bits.

Function
REQ-013 SHALL implement states IDLE, RUN and DONE; the transitions are IDLE->RUN on start, RUN->DONE after WIDTH bit steps, and DONE->IDLE unconditionally.
REQ-014 SHALL, on the accepting edge (IDLE and start=1), latch a, b and cin, clear bit index to 0, clear sum, set accumulated G to 0, and set accumulated P to 1.
REQ-015 SHALL, on each RUN edge, process bit i LSB-first through a single full-adder cell with inputs a[i], b[i] and the carry register.
REQ-016 SHALL, on each RUN edge, write the cell's S to sum[i] and the cell's C to the carry register.
REQ-017 SHALL, on each RUN edge, update the group terms as Gacc <= g_i | (p_i & Gacc) and Pacc <= p_i & Pacc, where g_i = a[i]&b[i] and p_i = a[i]^b[i].
REQ-018 SHALL enter DONE on the edge that processes bit WIDTH-1, so done is high in the cycle after the WIDTH-th edge following the accepting edge.
REQ-019 SHALL hold the carry register as cout, Gacc as g_all and Pacc as p_all.
REQ-020 SHALL make sum, cout, g_all and p_all valid in DONE and hold them through IDLE until the next accepting edge.
REQ-021 SHALL ignore start while in RUN or DONE, with no queueing and no effect on operands.
REQ-022 SHALL, if start is high in the IDLE cycle immediately after DONE, accept it normally, giving a throughput of one result per WIDTH+2 cycles.
REQ-023 SHALL keep the bit index WIDTH-bounded, with no wrap beyond WIDTH-1; the index counter SHALL be $clog2(WIDTH) bits wide.
REQ-024 SHALL ensure that changes on a, b and cin after the accepting edge do not affect the result.

Reset
REQ-025 SHALL, when rst=1 at a rising edge, force the state to IDLE, sum=0, cout=0, g_all=0, p_all=0, done=0, busy=0 and ready=1, regardless of state.
REQ-026 SHALL give rst priority over start; an operation in progress SHALL be aborted with no done pulse.
REQ-027 SHALL accept start on the first edge after rst is released.

Structure
REQ-028 SHALL place the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) in the shared ALU package/include used by the ALU blocks.
REQ-029 SHALL instantiate exactly one full_adder_gp cell (port order S, C, G, P, A, B, C0) as its only sub-module, reusing the cell's G/P outputs for g_i and p_i.
REQ-030 SHALL treat unused state encoding 2'd3 as IDLE on the next edge.

Verification (WIDTH=8)
REQ-031 SHALL cover reset: hold rst for 2 cycles -> ready=1, busy=0, done=0, sum=8'h00, cout=0, g_all=0, p_all=0.
REQ-032 SHALL cover a carry chain: a=8'hFF, b=8'h01, cin=0 -> done exactly 8 edges after the accepting edge, with sum=8'h00, cout=1, g_all=1, p_all=0.
REQ-033 SHALL cover full propagate: a=8'hAA, b=8'h55, cin=1 -> sum=8'h00, cout=1, g_all=0, p_all=1.
REQ-034 SHALL cover operand isolation: a=8'h0F, b=8'h01, cin=0, with start pulsed again and a/b changed during RUN -> second start ignored, sum=8'h10, cout=0, g_all=0, p_all=0, and a single done pulse.
REQ-035 SHALL cover reset mid-operation: rst on the 4th RUN edge -> IDLE next cycle, sum=8'h00, no done pulse; a new start then gives a correct result.
REQ-036 SHALL cover back-to-back operation: start held high continuously with 8'h01+8'h01 -> results 8'h02 every 10 cycles, with done pulses spaced exactly 10 cycles apart.
